reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Consumer end of the one-shot startup reset: takes the active-high power-on pulse and turns it into an ordered, acknowledged release of N downstream reset domains.
- Domains are, for example: DAC/ADC interfaces, then filter pipeline, then servo loop, then host interface.
- Each domain is released only after the previous one reports init-done, with a timeout per stage and a sticky fault report.
- Sits directly between the startup reset generator and the subsystem reset inputs in the servo top level.

Parameters:
- N_STAGES, 4, number of sequenced reset domains (1..8).
- HOLD_CYCLES, 30'd100, cycles all domains stay in reset after por_pulse falls.
- GAP_CYCLES, 30'd10, cycles between one stage's ack and the next stage's release (>=1).
- TIMEOUT, 30'd1000, max cycles to wait for a stage's stage_done after its release.
- MAX_RETRY, 3, retry limit; used only with AUTO_RETRY_EN.

Ports:
- clk_in  input  1  system clock
- rst_n  input  1  synchronous, active-low reset
- por_pulse  input  1  active-high one-shot startup reset pulse
- stage_done  input  N_STAGES  per-domain init-done; level, sampled on clk_in
- stage_rst  output  N_STAGES  per-domain reset, active-high, registered
- all_ready  output  1  high when every stage has been released and acknowledged
- fault  output  1  sticky, high when a stage timed out
- fault_stage  output  8  index of the stage that timed out

Behaviour:
- All outputs are registered. 30-bit counter cnt; stage index idx.
- rst_n=0 (sampled on a clk_in edge):
  - state=IDLE, stage_rst=all 1s, all_ready=0, fault=0, fault_stage=0, cnt=0, idx=0.
  - Also applies mid-sequence: all domains are re-held immediately on the next edge.
- por_pulse=1 in any state:
  - Next state HOLD, cnt=0, stage_rst=all 1s, all_ready=0, fault=0, fault_stage=0, idx=0.
  - This restarts the sequence and has the highest priority after rst_n.
- IDLE: stage_rst all 1s; waits for por_pulse.
- HOLD:
  - While por_pulse=0, cnt increments each cycle.
  - On the cycle cnt==HOLD_CYCLES-1: go to WAIT_ACK, clear stage_rst[0], cnt=0.
  - stage_rst[0] therefore falls HOLD_CYCLES edges after the first edge that samples por_pulse=0.
- WAIT_ACK(idx): cnt increments; only stage_done[idx] is observed, other bits are ignored.
  - stage_done[idx]=1 and idx==N_STAGES-1: go to DONE; all_ready=1 on that edge.
  - stage_done[idx]=1 and idx<N_STAGES-1: go to GAP, cnt=0.
  - cnt==TIMEOUT-1 with no ack: go to FAULT; stage_rst=all 1s, fault=1, fault_stage=idx.
  - Ack and timeout in the same cycle: the ack wins.
- GAP: on cnt==GAP_CYCLES-1, idx++, clear stage_rst[idx], cnt=0, go to WAIT_ACK.
- Released stages stay released. Stage_rst bits are cleared strictly in order 0..N-1 and never re-asserted except by FAULT, por_pulse or rst_n.
- DONE: holds all_ready=1. A later drop of stage_done is ignored; only por_pulse or rst_n leaves DONE.
- FAULT: holds all resets asserted, with fault and fault_stage stable; exits only on por_pulse or rst_n.
- Counters never wrap: cnt is bounded by max(HOLD_CYCLES, GAP_CYCLES, TIMEOUT) < 2^30.

Optional Feature:
- Macro: RESET_SEQ_AUTO_RETRY_EN.
- Defined:
  - A timeout re-enters HOLD (stage_rst all 1s, idx=0) instead of FAULT.
  - An internal retry counter increments on each timeout.
  - FAULT is entered only on the timeout that occurs after MAX_RETRY retries have already been spent; fault_stage is the stage that failed last.
  - The retry counter clears on por_pulse, rst_n, or on reaching DONE.
- Undefined: the first timeout goes to FAULT; MAX_RETRY has no effect.
- Port list is identical either way.

Test Plan (N_STAGES=3, HOLD_CYCLES=4, GAP_CYCLES=2, TIMEOUT=8 unless noted):
1. Hold rst_n=0 for 3 cycles, then release with por_pulse=0 -> stage_rst=3'b111, all_ready=0, fault=0 throughout; the block stays in IDLE.
2. por_pulse high for 5 cycles, then low; each stage acks 1 cycle after its release:
   - stage_rst[0] falls 4 edges after por_pulse is sampled low.
   - stage_rst[1] falls 3 edges after ack0 (1 edge into GAP + 2 GAP cycles); stage_rst[2] likewise after ack1.
   - all_ready=1 on the edge that samples ack2.
3. Stage 1 never acks -> FAULT 8 cycles after stage_rst[1] falls: stage_rst=3'b111, fault=1, fault_stage=1, all_ready=0; stable until por_pulse.
4. stage_done[idx] asserted exactly at cnt==TIMEOUT-1 -> ack wins, no fault. Separately, stage_done[2] pulsing while idx=0 -> ignored, stage_rst[2] stays 1.
5. por_pulse re-asserted while in DONE, and again mid-WAIT_ACK(1) -> next edge: stage_rst=3'b111, all_ready=0, fault=0; the full sequence then replays with identical timing.
6. With RESET_SEQ_AUTO_RETRY_EN and MAX_RETRY=2, stage 0 never acks -> 2 full HOLD/retry cycles, then fault=1 with fault_stage=0. Acking on the 2nd retry instead -> DONE, fault stays 0.

Source files
------------

// File: rtl/reset_sequencer.sv
// Ordered reset release: holds all domains after the POR pulse, then frees them one by one on ack.
// Optional macro RESET_SEQ_AUTO_RETRY_EN: a stage timeout restarts the hold up to MAX_RETRY times.
module reset_sequencer #(
  parameter int unsigned N_STAGES    = 4,
  parameter logic [29:0] HOLD_CYCLES = 30'd100,
  parameter logic [29:0] GAP_CYCLES  = 30'd10,
  parameter logic [29:0] TIMEOUT     = 30'd1000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                por_pulse,
  input  logic [N_STAGES-1:0] stage_done,
  output logic [N_STAGES-1:0] stage_rst,
  output logic                all_ready,
  output logic                fault,
  output logic [7:0]          fault_stage
);

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StWaitAck,
    StGap,
    StDone,
    StFault
  } state_e;

  localparam logic [N_STAGES-1:0] AllRst  = '1;
  localparam logic [2:0]          LastIdx = 3'(N_STAGES - 1);

`ifdef RESET_SEQ_AUTO_RETRY_EN
  localparam logic [7:0] RetryLimit = 8'(MAX_RETRY);
`else
  // Retries disabled: a zero limit sends the first timeout straight to the fault state.
  localparam logic [7:0] RetryLimit = 8'(MAX_RETRY) & 8'h00;
`endif

  state_e              state_q;
  logic [29:0]         cnt_q;
  logic [2:0]          idx_q;
  logic [7:0]          retry_q;

  logic [7:0]          done_ext;
  logic                ack;
  logic [2:0]          idx_nxt;
  logic [N_STAGES-1:0] next_mask;

  // Only the stage currently being waited on is looked at.
  always_comb begin
    done_ext  = 8'(stage_done);
    ack       = done_ext[idx_q];
    idx_nxt   = idx_q + 3'd1;
    next_mask = N_STAGES'(1) << idx_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      stage_rst   <= AllRst;
      all_ready   <= 1'b0;
      fault       <= 1'b0;
      fault_stage <= 8'd0;
      cnt_q       <= 30'd0;
      idx_q       <= 3'd0;
      retry_q     <= 8'd0;
    end else if (por_pulse) begin
      state_q     <= StHold;
      stage_rst   <= AllRst;
      all_ready   <= 1'b0;
      fault       <= 1'b0;
      fault_stage <= 8'd0;
      cnt_q       <= 30'd0;
      idx_q       <= 3'd0;
      retry_q     <= 8'd0;
    end else begin
      case (state_q)
        StIdle: begin
          stage_rst <= AllRst;
        end
        StHold: begin
          if (cnt_q == HOLD_CYCLES - 30'd1) begin
            state_q      <= StWaitAck;
            stage_rst[0] <= 1'b0;
            cnt_q        <= 30'd0;
          end else begin
            cnt_q <= cnt_q + 30'd1;
          end
        end
        StWaitAck: begin
          if (ack) begin
            cnt_q <= 30'd0;
            if (idx_q == LastIdx) begin
              state_q   <= StDone;
              all_ready <= 1'b1;
              retry_q   <= 8'd0;
            end else begin
              state_q <= StGap;
            end
          end else if (cnt_q == TIMEOUT - 30'd1) begin
            stage_rst <= AllRst;
            cnt_q     <= 30'd0;
            idx_q     <= 3'd0;
            if (retry_q != RetryLimit) begin
              state_q <= StHold;
              retry_q <= retry_q + 8'd1;
            end else begin
              state_q     <= StFault;
              fault       <= 1'b1;
              fault_stage <= 8'(idx_q);
            end
          end else begin
            cnt_q <= cnt_q + 30'd1;
          end
        end
        StGap: begin
          if (cnt_q == GAP_CYCLES - 30'd1) begin
            state_q   <= StWaitAck;
            idx_q     <= idx_nxt;
            stage_rst <= stage_rst & ~next_mask;
            cnt_q     <= 30'd0;
          end else begin
            cnt_q <= cnt_q + 30'd1;
          end
        end
        StDone, StFault: begin
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
